// File: rtl/rc_filter_array.sv
// rc_filter_array: multi-channel input conditioner that replaces RC low-pass
// and debounce networks. Each channel runs a two-flop synchroniser and then
// one of two filters:
//   MODE 0: saturating integrator with hysteresis (models RC charge/discharge)
//   MODE 1: stable-sample debouncer
// Each channel produces a clean level and one-cycle rise/fall strobes.
// A shared prescaler sets the filter sample rate.
module rc_filter_array #(
  parameter int CHANNELS    = 4,
  parameter int CNT_WIDTH   = 8,
  parameter int MODE        = 0,
  parameter int RISE_THRESH = 192,
  parameter int FALL_THRESH = 64,
  parameter int PRESCALE    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                tick
);

  localparam int CMAX = (1 << CNT_WIDTH) - 1;
  localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [CNT_WIDTH-1:0] CMAX_C = '1;
  localparam logic [CNT_WIDTH-1:0] RISE_C = CNT_WIDTH'(RISE_THRESH);
  localparam logic [CNT_WIDTH-1:0] FALL_C = CNT_WIDTH'(FALL_THRESH);
  localparam logic [PC_W-1:0]      PC_LAST = PC_W'(PRESCALE - 1);

  // Reject parameter sets that would make the filter meaningless.
  if (CHANNELS < 1 || PRESCALE < 1 || CNT_WIDTH < 1 || CNT_WIDTH > 30) begin : g_bad_geometry
    $error("rc_filter_array: illegal CHANNELS/PRESCALE/CNT_WIDTH");
  end
  if (MODE == 0) begin : g_chk_mode0
    if (!(FALL_THRESH >= 0 && FALL_THRESH < RISE_THRESH && RISE_THRESH <= CMAX)) begin : g_bad
      $error("rc_filter_array: mode 0 needs FALL_THRESH < RISE_THRESH <= CMAX");
    end
  end else if (MODE == 1) begin : g_chk_mode1
    if (!(RISE_THRESH >= 1 && RISE_THRESH <= CMAX &&
          FALL_THRESH >= 1 && FALL_THRESH <= CMAX)) begin : g_bad
      $error("rc_filter_array: mode 1 needs 1 <= thresholds <= CMAX");
    end
  end else begin : g_bad_mode
    $error("rc_filter_array: MODE must be 0 or 1");
  end

  logic [CHANNELS-1:0]  s1_q, s2_q;
  logic [PC_W-1:0]      pc_q;
  logic                 tick_q;
  logic                 step_en;
  logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d [CHANNELS];
  logic [CHANNELS-1:0]  dout_q, dout_d;
  logic [CHANNELS-1:0]  rise_q, rise_d;
  logic [CHANNELS-1:0]  fall_q, fall_d;

  // The filters advance on the same edge that raises tick.
  assign step_en = (pc_q == PC_LAST);

  // Two-flop synchroniser, clocked every cycle independent of the prescaler.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse s1 and s2 into one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

  // Prescaler: pc wraps at PRESCALE-1; tick is the registered wrap strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= step_en;
      pc_q   <= step_en ? '0 : pc_q + PC_W'(1);
    end
  end

  // Per-channel filter next-state: integrator or debouncer, plus edge detect.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      // NOTE: every output of this block gets a hold value before any branch,
      // so no path leaves it unassigned and no latch is inferred.
      cnt_d[i]  = cnt_q[i];
      dout_d[i] = dout_q[i];
      if (step_en) begin
        if (MODE == 0) begin
          if (s2_q[i] && cnt_q[i] != CMAX_C) begin
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
          end else if (!s2_q[i] && cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
          end
          // Hysteresis band: between the thresholds the level holds.
          if (cnt_d[i] >= RISE_C) begin
            dout_d[i] = 1'b1;
          end else if (cnt_d[i] <= FALL_C) begin
            dout_d[i] = 1'b0;
          end
        end else begin
          if (s2_q[i] == dout_q[i]) begin
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            // The threshold depends on which way the level is trying to move.
            if (cnt_d[i] == (dout_q[i] ? FALL_C : RISE_C)) begin
              dout_d[i] = s2_q[i];
              cnt_d[i]  = '0;
            end
          end
        end
      end
    end
    // On non-tick cycles dout_d equals dout_q, so both strobes fall to 0.
    rise_d = dout_d & ~dout_q;
    fall_d = ~dout_d & dout_q;
  end

  // Filter state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the counter array is ordinary state, not a RAM, and must clear
      // on reset so filtering restarts from an empty integrator.
      cnt_q  <= '{default: '0};
      dout_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_rc_filter_array.sv
// Testbench for rc_filter_array: directed vectors over four configurations
// (default integrator, debouncer, prescaled integrator, 8-channel array).
module tb_rc_filter_array;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default configuration: 4 channels, mode 0, 192/64, PRESCALE 1.
  logic [3:0] din_def, dout_def, rise_def, fall_def;
  logic       tick_def;
  // Debouncer: mode 1, rise 5, fall 3.
  logic [0:0] din_m1, dout_m1, rise_m1, fall_m1;
  logic       tick_m1;
  // Prescaled integrator: PRESCALE 4, rise 2, fall 0.
  logic [0:0] din_ps, dout_ps, rise_ps, fall_ps;
  logic       tick_ps;
  // Eight channels, 4-bit counters (CMAX 15), rise 3, fall 1.
  logic [7:0] din_mc, dout_mc, rise_mc, fall_mc;
  logic       tick_mc;

  rc_filter_array u_def (
    .clk(clk), .rst(rst), .din(din_def), .dout(dout_def),
    .rise(rise_def), .fall(fall_def), .tick(tick_def)
  );

  rc_filter_array #(.CHANNELS(1), .MODE(1), .RISE_THRESH(5), .FALL_THRESH(3)) u_m1 (
    .clk(clk), .rst(rst), .din(din_m1), .dout(dout_m1),
    .rise(rise_m1), .fall(fall_m1), .tick(tick_m1)
  );

  rc_filter_array #(.CHANNELS(1), .PRESCALE(4), .RISE_THRESH(2), .FALL_THRESH(0)) u_ps (
    .clk(clk), .rst(rst), .din(din_ps), .dout(dout_ps),
    .rise(rise_ps), .fall(fall_ps), .tick(tick_ps)
  );

  rc_filter_array #(.CHANNELS(8), .CNT_WIDTH(4), .RISE_THRESH(3), .FALL_THRESH(1)) u_mc (
    .clk(clk), .rst(rst), .din(din_mc), .dout(dout_mc),
    .rise(rise_mc), .fall(fall_mc), .tick(tick_mc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Debouncer vector segments: din held for len edges, expected outputs after each.
  typedef struct {
    int   len;
    logic din;
    logic dout;
    logic rise;
    logic fall;
  } seg_t;

  seg_t segs [10];

  initial begin
    int first;
    int cnt_ev;
    int other;
    int max_cnt;
    int k;
    logic [3:0]  e4;
    logic [15:0] e16;
    logic [23:0] e24;

    segs = '{
      '{2, 1'b0, 1'b0, 1'b0, 1'b0},  // edges 1-2 idle
      '{4, 1'b1, 1'b0, 1'b0, 1'b0},  // 4-cycle pulse: rejected
      '{3, 1'b0, 1'b0, 1'b0, 1'b0},
      '{6, 1'b1, 1'b0, 1'b0, 1'b0},  // long pulse, edges 10-15
      '{1, 1'b1, 1'b1, 1'b1, 1'b0},  // edge 16 = 7th edge of pulse: rise
      '{2, 1'b0, 1'b1, 1'b0, 1'b0},  // 2-cycle dip: rejected
      '{3, 1'b1, 1'b1, 1'b0, 1'b0},
      '{4, 1'b0, 1'b1, 1'b0, 1'b0},  // sustained low from edge 22
      '{1, 1'b0, 1'b0, 1'b0, 1'b1},  // edge 26 = 5th edge of low: fall
      '{2, 1'b0, 1'b0, 1'b0, 1'b0}
    };

    din_def = '0;
    din_m1  = '0;
    din_ps  = '0;
    din_mc  = '0;

    // ---------------- reset state and reset mid-operation (ch0)
    rst = 1'b1;
    repeat (2) step();
    check("reset dout", 32'(dout_def), 0);
    check("reset rise/fall", 32'({rise_def, fall_def}), 0);
    check("reset tick", 32'(tick_def), 0);
    din_def[0] = 1'b1;
    rst = 1'b0;
    step();
    check("tick after first edge", 32'(tick_def), 1);
    repeat (149) step();
    check("ch0 cnt after 150 edges", 32'(u_def.cnt_q[0]), 148);
    check("ch0 dout before thresh", 32'(dout_def[0]), 0);
    rst = 1'b1;
    #1;
    check("async reset cnt", 32'(u_def.cnt_q[0]), 0);
    check("async reset outputs", 32'({dout_def, rise_def, fall_def, tick_def}), 0);
    repeat (2) step();
    rst = 1'b0;
    first = -1;
    for (int t = 1; t <= 300 && first < 0; t++) begin
      step();
      if (rise_def[0]) first = t;
    end
    check("ch0 rise edge after reset", first, 194);
    // Reset while the rise strobe and dout are high: no fall strobe results.
    rst = 1'b1;
    #1;
    check("reset mid-strobe outputs", 32'({dout_def, rise_def, fall_def}), 0);
    cnt_ev = 0;
    repeat (3) begin
      step();
      if (fall_def != 0 || dout_def != 0) cnt_ev++;
    end
    check("no strobe from reset", cnt_ev, 0);

    // ---------------- mode 0 hysteresis on ch1
    din_def = 4'b0010;
    rst = 1'b0;
    first = -1; cnt_ev = 0; other = 0;
    for (int t = 1; t <= 300; t++) begin
      step();
      if (rise_def[1]) begin
        cnt_ev++;
        if (first < 0) first = t;
      end
      if ((rise_def & 4'b1101) != 0) other++;
    end
    check("ch1 rise edge", first, 194);
    check("ch1 rise pulse count", cnt_ev, 1);
    check("other channels quiet", other, 0);
    check("ch1 cnt saturated", 32'(u_def.cnt_q[1]), 255);
    check("dout after rise", 32'(dout_def), 32'h2);
    din_def[1] = 1'b0;
    first = -1; cnt_ev = 0;
    for (int t = 1; t <= 200; t++) begin
      step();
      if (fall_def[1]) begin
        cnt_ev++;
        if (first < 0) first = t;
      end
    end
    check("ch1 fall edge", first, 193);
    check("ch1 fall pulse count", cnt_ev, 1);
    check("ch1 dout after fall", 32'(dout_def[1]), 0);
    check("ch1 cnt after 200 low edges", 32'(u_def.cnt_q[1]), 57);

    // ---------------- mode 0 glitch rejection on ch2
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    cnt_ev = 0; max_cnt = 0;
    for (int t = 0; t < 1000; t++) begin
      din_def[2] = ((t / 4) % 2) == 1;
      step();
      if (rise_def[2] || fall_def[2] || dout_def[2]) cnt_ev++;
      if (int'(u_def.cnt_q[2]) > max_cnt) max_cnt = int'(u_def.cnt_q[2]);
    end
    check("ch2 glitch no activity", cnt_ev, 0);
    check("ch2 glitch peak count", max_cnt, 4);
    din_def = '0;

    // ---------------- mode 1 debounce, table-driven
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    k = 0;
    for (int s = 0; s < 10; s++) begin
      for (int j = 0; j < segs[s].len; j++) begin
        k++;
        din_m1[0] = segs[s].din;
        step();
        check($sformatf("m1 edge %0d {dout,rise,fall}", k),
              32'({dout_m1, rise_m1, fall_m1}),
              32'({segs[s].dout, segs[s].rise, segs[s].fall}));
      end
    end

    // ---------------- prescaler 4, mode 0, thresholds 2/0
    rst = 1'b1;
    repeat (2) step();
    check("ps reset tick", 32'(tick_ps), 0);
    din_ps = 1'b1;
    rst = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      step();
      e4 = {(t % 4) == 0, t >= 8, t == 8, 1'b0};
      check($sformatf("ps edge %0d {tick,dout,rise,fall}", t),
            32'({tick_ps, dout_ps, rise_ps, fall_ps}), 32'(e4));
    end

    // ---------------- 8 channels: simultaneous rise, then staggered fall
    rst = 1'b1;
    repeat (2) step();
    din_mc = 8'hFF;
    rst = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      step();
      e16 = {(t >= 5) ? 8'hFF : 8'h00, (t == 5) ? 8'hFF : 8'h00};
      check($sformatf("mc rise edge %0d {dout,rise}", t),
            32'({dout_mc, rise_mc}), 32'(e16));
    end
    repeat (24) step();
    check("mc cnt saturated", 32'(u_mc.cnt_q[7]), 15);
    for (int t = 1; t <= 24; t++) begin
      din_mc = 8'hFF << t;
      step();
      e24[23:16] = (t >= 16) ? (8'hFF << (t - 15)) : 8'hFF;
      e24[15:8]  = (t >= 16 && t <= 23) ? (8'h01 << (t - 16)) : 8'h00;
      e24[7:0]   = 8'h00;
      check($sformatf("mc stagger edge %0d {dout,fall,rise}", t),
            32'({dout_mc, fall_mc, rise_mc}), 32'(e24));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
